imem_fetch_unit: RTL and testbench

Instruction-fetch responder for the pipelined CPU. It accepts the fetch address driven by the program-counter register, reads the instruction from an internal word-addressed instruction memory after a fixed multi-cycle latency, and returns it to the IF/ID stage. While a fetch is outstanding it drives `stall_o` back to the PC, so the PC holds its value. It also supports flush on taken branches and flags misaligned or out-of-range addresses.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/imem_array.sv | 30 +++
 rtl/imem_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_imem_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, canonical NOP and the
// instruction-fetch FSM state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction RAM: one write port, one registered
// read port, read-before-write when both hit the same word.
module imem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // Write commit and registered read; nonblocking gives old data on a collision
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction-fetch responder: fixed-latency read of the internal
// instruction RAM with PC stall, branch flush and address checking.
module imem_fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_i,
  input  logic [XLEN-1:0]                pc_i,
  input  logic                           flush_i,
  input  logic                           wr_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr_i,
  input  logic [XLEN-1:0]                wr_data_i,
  output logic [XLEN-1:0]                instr_o,
  output logic                           valid_o,
  output logic                           addr_err_o,
  output logic                           stall_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_START = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam bit SINGLE = (LATENCY == 1);

  fetch_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q;
  logic err_q;
  logic ok_q;

  logic is_idle, is_wait, is_resp;
  logic accept;
  logic rd_fire;
  logic [XLEN-1:0] rd_addr;
  logic rd_err;
  logic [XLEN-1:0] rd_data;

  assign is_idle = (state_q == S_IDLE);
  assign is_wait = (state_q == S_WAIT);
  assign is_resp = (state_q == S_RESP);

  assign accept = is_idle & req_i & ~flush_i;

  // Single-cycle latency reads on the acceptance edge, before addr_q
  // holds the PC, so the live PC is used in IDLE.
  assign rd_addr = is_idle ? pc_i : addr_q;

  assign rd_err = (|rd_addr[1:0]) | (|(rd_addr >> (AW + 2)));

  // Read edge: acceptance when single-cycle, else last WAIT cycle
  always_comb begin
    rd_fire = 1'b0;
    if (SINGLE) begin
      rd_fire = accept;
    end else begin
      rd_fire = is_wait & (cnt_q == CNT_ONE) & ~flush_i;
    end
  end

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk_i),
    .wr_en  (wr_en_i),
    .wr_addr(wr_addr_i),
    .wr_data(wr_data_i),
    .rd_en  (rd_fire & ~rd_err & ~rst_i),
    .rd_addr(rd_addr[AW+1:2]),
    .rd_data(rd_data)
  );

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (SINGLE) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_START;
          end
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, latched PC and response qualifiers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= pc_i;
      end
      if (rd_fire) begin
        err_q <= rd_err;
        ok_q  <= ~rd_err;
      end
    end
  end

  assign instr_o    = ok_q ? rd_data : INSTR_NOP;
  assign addr_err_o = err_q;
  assign valid_o    = is_resp & ~flush_i;
  assign stall_o    = ~flush_i & ((is_idle & req_i) | is_wait);

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: two instances (latency 2 and 1) on
// shared stimulus, checked against a word-array reference model.
module tb_imem_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] a_instr, b_instr;
  logic        a_valid, b_valid, a_err, b_err, a_stall, b_stall;

  bit sel = 1'b0;
  wire [31:0] instr = sel ? b_instr : a_instr;
  wire        valid = sel ? b_valid : a_valid;
  wire        aerr  = sel ? b_err   : a_err;
  wire        stall = sel ? b_stall : a_stall;

  int total = 0;
  int passed = 0;
  logic [31:0] mem_m [256];

  always #5 clk = ~clk;

  imem_fetch_unit #(.DEPTH_WORDS(256), .LATENCY(2)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .pc_i(pc),
    .flush_i(flush), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .instr_o(a_instr), .valid_o(a_valid),
    .addr_err_o(a_err), .stall_o(a_stall)
  );

  imem_fetch_unit #(.DEPTH_WORDS(256), .LATENCY(1)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .pc_i(pc),
    .flush_i(flush), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .instr_o(b_instr), .valid_o(b_valid),
    .addr_err_o(b_err), .stall_o(b_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    logic [7:0] w;
    w = a[9:2];
    return exp_err(a) ? INSTR_NOP : mem_m[w];
  endfunction

  // Write lands in the model at the edge that ends the current cycle
  task automatic commit_and_tick();
    if (wr_en) mem_m[wr_addr] = wr_data;
    tick();
  endtask

  task automatic gap(input int n);
    req = 1'b0; flush = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < n; i++) commit_and_tick();
  endtask

  // One fetch on the selected instance; optional flush at cycle fl,
  // random writes with probability pct, forced write of wv at cycle wat
  task automatic fetch(input logic [31:0] a, input int fl, input int pct,
                       input int wat, input logic [31:0] wv);
    int L;
    logic [31:0] e_i;
    logic        e_e;
    L = sel ? 1 : 2;
    e_i = INSTR_NOP;
    e_e = 1'b0;
    for (int k = 0; k <= L; k++) begin
      req = (k == 0);
      pc = a;
      flush = (k == fl);
      wr_en = 1'b0;
      if (k == wat) begin
        wr_en = 1'b1; wr_addr = a[9:2]; wr_data = wv;
      end else if ($urandom_range(99) < pct) begin
        wr_en = 1'b1;
        wr_addr = ($urandom_range(1) == 1) ? a[9:2] : 8'($urandom);
        wr_data = $urandom;
      end
      #1;
      if (k == fl) begin
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_valid", {31'd0, valid}, 32'd0);
        commit_and_tick();
        req = 1'b0; flush = 1'b0; wr_en = 1'b0;
        return;
      end
      if (k < L) begin
        chk("wait_stall", {31'd0, stall}, 32'd1);
        chk("wait_valid", {31'd0, valid}, 32'd0);
      end else begin
        chk("resp_valid", {31'd0, valid}, 32'd1);
        chk("resp_stall", {31'd0, stall}, 32'd0);
        chk("resp_instr", instr, e_i);
        chk("resp_err", {31'd0, aerr}, {31'd0, e_e});
      end
      if (k == L - 1) begin
        e_e = exp_err(a);
        e_i = exp_instr(a);
      end
      commit_and_tick();
    end
    req = 1'b0; flush = 1'b0; wr_en = 1'b0;
    #1;
    chk("hold_valid", {31'd0, valid}, 32'd0);
    chk("hold_instr", instr, e_i);
    chk("hold_err", {31'd0, aerr}, {31'd0, e_e});
  endtask

  initial begin
    logic [31:0] a;
    int fl;

    // Reset with request held high
    sel = 1'b0;
    rst = 1'b1; req = 1'b1; pc = 32'h0000_000C;
    tick();
    tick();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instr, INSTR_NOP);
    chk("rst_err", {31'd0, aerr}, 32'd0);
    chk("rst_idle_stall", {31'd0, stall}, 32'd1);
    sel = 1'b1;
    #1;
    chk("rst_instr_b", instr, INSTR_NOP);
    chk("rst_valid_b", {31'd0, valid}, 32'd0);
    rst = 1'b0; req = 1'b0;
    #1;
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    sel = 1'b0;

    // Preload the memory
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = $urandom;
      commit_and_tick();
    end
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'h00A0_0093;
    commit_and_tick();
    gap(1);

    // Basic fetch on both latencies
    fetch(32'h0000_000C, -1, 0, -1, 0);
    gap(2);
    sel = 1'b1;
    fetch(32'h0000_000C, -1, 0, -1, 0);
    gap(2);
    sel = 1'b0;

    // Back-to-back with req held high
    for (int k = 0; k < 6; k++) begin
      req = 1'b1;
      pc = (k < 2) ? 32'd0 : 32'd4;
      #1;
      chk("b2b_stall", {31'd0, stall}, (k % 3 != 2) ? 32'd1 : 32'd0);
      chk("b2b_valid", {31'd0, valid}, (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k == 2) chk("b2b_instr0", instr, mem_m[0]);
      if (k == 5) chk("b2b_instr1", instr, mem_m[1]);
      commit_and_tick();
    end
    gap(2);

    // Flush in first WAIT, new request the following cycle
    fetch(32'h0000_0008, 1, 0, -1, 0);
    fetch(32'h0000_0010, -1, 0, -1, 0);
    gap(2);

    // Address errors
    fetch(32'h0000_0006, -1, 0, -1, 0);
    gap(2);
    fetch(32'h0000_0400, -1, 0, -1, 0);
    gap(2);

    // Write/read collision on the read edge, then readback
    fetch(32'h0, -1, 0, 1, 32'hDEAD_BEEF);
    gap(2);
    fetch(32'h0, -1, 0, -1, 0);
    gap(2);
    sel = 1'b1;
    fetch(32'h4, -1, 0, 0, 32'hCAFE_F00D);
    gap(2);
    fetch(32'h4, -1, 0, -1, 0);
    gap(2);
    sel = 1'b0;

    // Reset mid-fetch abandons the response
    req = 1'b1; pc = 32'h8;
    commit_and_tick();
    req = 1'b0; rst = 1'b1;
    commit_and_tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_mid_valid", {31'd0, valid}, 32'd0);
      commit_and_tick();
    end

    // Randomized fetches across both instances
    for (int n = 0; n < 80; n++) begin
      sel = bit'($urandom_range(1));
      case ($urandom_range(9))
        0: a = {$urandom_range(255), 2'b00} | 32'($urandom_range(3));
        1: a = $urandom;
        default: a = {22'd0, 8'($urandom), 2'b00};
      endcase
      fl = ($urandom_range(4) == 0) ? int'($urandom_range(sel ? 1 : 2)) : -1;
      fetch(a, fl, 30, -1, 0);
      gap(2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
